// File: rtl/en_debounce_pkg.sv
// en_debounce_pkg: state encoding and default timing constants for en_debounce.
package en_debounce_pkg;
   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_e;
   localparam int DEB_CNT_DEF = 16;
   localparam int REP_CNT_DEF = 64;
endpackage

// File: rtl/en_debounce_sync2.sv
// sync2: two-flop synchronizer, async active-low reset to 0.
module sync2 (
   input  logic clk,
   input  logic res_,
   input  logic d_i,
   output logic q_o
);
   logic s1_q, s2_q;
   always_ff @(posedge clk or negedge res_) begin
      if (!res_) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end
   assign q_o = s2_q;
endmodule

// File: rtl/en_debounce.sv
// en_debounce: synchronizes and debounces a push-button, emitting one en pulse per press.
// Define BTN_AUTOREPEAT_EN to add a repeat pulse every REP_CNT cycles while held.
module en_debounce
   import en_debounce_pkg::*;
#(
   parameter int DEB_CNT = DEB_CNT_DEF,
   parameter int REP_CNT = REP_CNT_DEF,
   parameter int CNT_W   = 16
) (
   input  logic clk,
   input  logic res_,
   input  logic btn,
   output logic en,
   output logic btn_level
);
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CNT - 1);
   if (DEB_CNT < 2 || REP_CNT < 2 || (DEB_CNT - 1) >= (1 << CNT_W) || (REP_CNT - 1) >= (1 << CNT_W)) begin : g_bad_param
      $error("en_debounce: illegal DEB_CNT/REP_CNT/CNT_W combination");
   end
   logic s2;
   state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic en_q, en_d, lvl_q, lvl_d;
   sync2 u_sync (.clk(clk), .res_(res_), .d_i(btn), .q_o(s2));
   always_ff @(posedge clk or negedge res_) begin
      if (!res_) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         en_q    <= 1'b0;
         lvl_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         lvl_q   <= lvl_d;
      end
   end
   // Counter is cleared on every state change, so it never needs to wrap.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      en_d    = 1'b0;
      lvl_d   = lvl_q;
      unique case (state_q)
         IDLE: begin
            if (s2) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!s2) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d = PRESSED;
               cnt_d   = '0;
               en_d    = 1'b1;
               lvl_d   = 1'b1;
            end else
               cnt_d = cnt_q + 1'b1;
         end
         PRESSED: begin
            if (!s2) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end
`ifdef BTN_AUTOREPEAT_EN
            else if (cnt_q == CNT_W'(REP_CNT - 1)) begin
               cnt_d = '0;
               en_d  = 1'b1;
            end else
               cnt_d = cnt_q + 1'b1;
`else
            else
               cnt_d = '0;
`endif
         end
         RELEASE_WAIT: begin
            if (s2) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               lvl_d   = 1'b0;
            end else
               cnt_d = cnt_q + 1'b1;
         end
      endcase
   end
   assign en        = en_q;
   assign btn_level = lvl_q;
endmodule
